// File: rtl/aes_pkg.sv
// Shared AES constants for the key schedule: round count, key length,
// the round-constant table and the key-schedule FSM state encoding.
package aes_pkg;

  localparam int AES_NR    = 10;  // AES-128 rounds
  localparam int KEY_BYTES = 16;  // bytes per round key / cipher key

  // Rcon[1..10] stored at index 0..9
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    READY,
    STREAM
  } state_t;

endpackage

// File: rtl/sub_bytes.sv
// AES byte substitution, purely combinational.
//   mode : 0 = forward S-box, 1 = inverse S-box
//   din  : input byte
//   dout : substituted byte
// Computed as GF(2^8) inversion plus the AES affine map instead of a
// 256-entry table, so one block serves both directions.
module sub_bytes (
  input  logic       mode,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // multiply in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 == a^-1 (and maps 0 to 0); exponent 254 = 2+4+...+128
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int n = 0; n < 7; n++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] f_inv, i_aff;

  always_comb begin
    f_inv = ginv(din);
    // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    i_aff = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    if (mode)
      dout = ginv(i_aff);
    else
      // forward affine: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
      dout = f_inv ^ {f_inv[6:0], f_inv[7]} ^ {f_inv[5:0], f_inv[7:6]} ^
             {f_inv[4:0], f_inv[7:5]} ^ {f_inv[3:0], f_inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_schedule_serial.sv
// Byte-serial AES-128 key expansion and round-key server.
//   clk, rst       : clock, asynchronous active-high reset
//   key_in/key_valid : cipher key bytes, byte 0 first (FIPS-197 order)
//   rk_start/rk_round : request a 16-byte stream of round key rk_round
//   key_out/key_out_valid : round-key bytes, one cycle after rk_start
//   keys_ready     : all round keys expanded and stored
//   busy           : loading, expanding or streaming
//   rk_err         : one-cycle pulse after a rejected rk_start
// Expansion writes one byte per cycle into w[0..175]; streaming reads
// w[16*round + k]. A request in the cycle showing byte 15 chains the next
// stream with no bubble.
module key_schedule_serial
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    key_in,
  input  logic          key_valid,
  input  logic          rk_start,
  input  logic [RW-1:0] rk_round,
  output logic [7:0]    key_out,
  output logic          key_out_valid,
  output logic          keys_ready,
  output logic          busy,
  output logic          rk_err
);

  localparam int         DEPTH = KEY_BYTES * (NR + 1);
  localparam logic [7:0] LAST  = 8'(DEPTH - 1);

  state_t     state, state_d;
  logic [7:0] cnt;          // load count in LOAD, byte index i in EXPAND
  logic [7:0] base;         // 16*round of the stream in progress
  logic [3:0] k;            // index of the byte currently on key_out
  logic [7:0] w [DEPTH];

  logic       we;
  logic [7:0] waddr, wdata;
  logic [7:0] sb_idx, sb_out, rcon_b, t, exp_byte, new_base;
  logic       load_start, accept_ready, round_ok, rk_acc, rk_bad;

  assign load_start   = (state == IDLE || state == READY) && key_valid;
  // a key byte arriving in READY invalidates the schedule this cycle
  assign accept_ready = (state == READY) && !key_valid;
  assign round_ok     = int'(rk_round) <= NR;
  assign rk_acc       = rk_start && round_ok &&
                        (accept_ready || (state == STREAM && k == 4'd15));
  assign rk_bad       = rk_start && !rk_acc;
  assign new_base     = 8'({rk_round, 4'b0000});

  assign keys_ready = accept_ready || (state == STREAM);
  assign busy       = (state == LOAD) || (state == EXPAND) || (state == STREAM);

  // Expansion byte: j = i/4, b = i%4. For j%4==0 the source is the
  // rotated previous word, i.e. byte (b+1)%4 of word j-1.
  assign sb_idx = {cnt[7:2] - 6'd1, cnt[1:0] + 2'd1};

  sub_bytes u_sbox (
    .mode (1'b0),
    .din  (w[sb_idx]),
    .dout (sb_out)
  );

  always_comb begin
    rcon_b = 8'h00;
    if (cnt[1:0] == 2'd0) rcon_b = RCON[cnt[7:4] - 4'd1];
    if (cnt[3:2] == 2'd0)
      t = sb_out ^ rcon_b;
    else
      t = w[cnt - 8'd4];
    exp_byte = w[cnt - 8'd16] ^ t;
  end

  // single write port shared by LOAD and EXPAND
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = key_in;
    if (load_start) begin
      we    = 1'b1;
      waddr = 8'd0;
    end else if (state == LOAD) begin
      we = key_valid;
    end else if (state == EXPAND) begin
      we    = 1'b1;
      wdata = exp_byte;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (key_valid && cnt == 8'd15) state_d = EXPAND;
      EXPAND:  if (cnt == LAST) state_d = READY;
      READY: begin
        if (load_start)  state_d = LOAD;
        else if (rk_acc) state_d = STREAM;
      end
      STREAM:  if (k == 4'd15 && !rk_acc) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= 8'd0;
      base          <= 8'd0;
      k             <= 4'd0;
      key_out       <= 8'h00;
      key_out_valid <= 1'b0;
      rk_err        <= 1'b0;
    end else begin
      rk_err <= rk_bad;

      if (load_start)
        cnt <= 8'd1;
      else if ((state == LOAD && key_valid) || state == EXPAND)
        cnt <= cnt + 8'd1;

      if (rk_acc) begin
        base          <= new_base;
        k             <= 4'd0;
        key_out       <= w[new_base];
        key_out_valid <= 1'b1;
      end else if (state == STREAM && k != 4'd15) begin
        k             <= k + 4'd1;
        key_out       <= w[base | 8'(k + 4'd1)];
        key_out_valid <= 1'b1;
      end else begin
        key_out       <= 8'h00;
        key_out_valid <= 1'b0;
      end
    end
  end

  // storage is intentionally not reset; keys_ready guards its validity
  always_ff @(posedge clk) begin
    if (we) w[waddr] <= wdata;
  end

endmodule

// File: tb/tb_key_schedule_serial.sv
module tb_key_schedule_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       key_valid = 1'b0;
  logic       rk_start = 1'b0;
  logic [3:0] rk_round = 4'd0;
  logic [7:0] key_out;
  logic       key_out_valid, keys_ready, busy, rk_err;

  int checks = 0;
  int failures = 0;

  key_schedule_serial #(.NR(10), .RW(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .rk_start(rk_start), .rk_round(rk_round), .key_out(key_out),
    .key_out_valid(key_out_valid), .keys_ready(keys_ready), .busy(busy),
    .rk_err(rk_err)
  );

  always #5 clk = ~clk;

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // reference round keys, word-oriented FIPS-197 KeyExpansion
  logic [127:0] mdl [11];
  int rq [$];

  typedef struct {
    logic [127:0] key;
    int           gap;
    int           round;
    logic [127:0] expect_rk;
  } vec_t;
  vec_t vt [4];

  task automatic model(input logic [127:0] key);
    logic [31:0] wd [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = wd[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {SBOX[tmp[31:24]], SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      wd[i] = wd[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] key, input int gap, input bit chk_drop);
    int g;
    for (int b = 0; b < 16; b++) begin
      key_in    = key[127-8*b -: 8];
      key_valid = 1'b1;
      if (b == 0 && chk_drop) begin
        #1;
        chk("ready_drop_same_cycle", 128'(keys_ready), 128'(0));
      end
      tick;
      key_valid = 1'b0;
      key_in    = 8'h00;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (b < 15) repeat (g) tick;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!keys_ready && n < 1000) begin
      tick;
      n++;
    end
    chk("ready_timeout", 128'(keys_ready), 128'(1));
  endtask

  // streams the rounds in rq back to back; midk>=0 issues an illegal
  // rk_start while the first stream shows byte midk
  task automatic stream(input int midk, input string name);
    logic [127:0] got;
    int nv, errs;
    errs = 0;
    rk_round = 4'(rq[0]);
    rk_start = 1'b1;
    tick;
    rk_start = 1'b0;
    for (int s = 0; s < rq.size(); s++) begin
      got = '0;
      nv  = 0;
      for (int k = 0; k < 16; k++) begin
        got[127-8*k -: 8] = key_out;
        nv += int'(key_out_valid);
        errs += int'(rk_err);
        if (s == 0 && k == midk) begin
          rk_round = 4'd2;
          rk_start = 1'b1;
          tick;
          rk_start = 1'b0;
        end else if (k == 15 && s + 1 < rq.size()) begin
          rk_round = 4'(rq[s+1]);
          rk_start = 1'b1;
          tick;
          rk_start = 1'b0;
        end else begin
          tick;
        end
      end
      chk($sformatf("%s_r%0d_data", name, rq[s]), got, mdl[rq[s]]);
      chk($sformatf("%s_r%0d_valid_cnt", name, rq[s]), 128'(nv), 128'(16));
    end
    chk({name, "_idle_valid"}, 128'(key_out_valid), 128'(0));
    chk({name, "_idle_data"}, 128'(key_out), 128'(0));
    chk({name, "_err_cnt"}, 128'(errs), 128'((midk >= 0) ? 1 : 0));
  endtask

  task automatic bad_start(input logic [3:0] r, input string name);
    rk_round = r;
    rk_start = 1'b1;
    tick;
    rk_start = 1'b0;
    chk({name, "_err"}, 128'(rk_err), 128'(1));
    chk({name, "_no_valid"}, 128'(key_out_valid), 128'(0));
    tick;
    chk({name, "_err_clear"}, 128'(rk_err), 128'(0));
  endtask

  initial begin
    int n;
    logic [127:0] got, k1, k2, k3, kr;
    int nv;

    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 0, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 2, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 2, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    k1 = vt[0].key;
    k2 = vt[2].key;
    k3 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

    // reset state
    #1;
    chk("rst_key_out", 128'(key_out), 128'(0));
    chk("rst_valid", 128'(key_out_valid), 128'(0));
    chk("rst_ready", 128'(keys_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(rk_err), 128'(0));
    tick;
    rst = 1'b0;
    tick;

    bad_start(4'd1, "before_any_key");

    // known-answer table
    for (int v = 0; v < 4; v++) begin
      if (v == 0 || vt[v].key != vt[v-1].key) begin
        load_key(vt[v].key, vt[v].gap, 1'b0);
        if (v == 0) chk("busy_in_expand", 128'(busy), 128'(1));
        wait_ready(n);
        if (v == 0) chk("ready_latency", 128'(n), 128'(160));
      end
      rk_round = 4'(vt[v].round);
      rk_start = 1'b1;
      tick;
      rk_start = 1'b0;
      got = '0;
      nv  = 0;
      for (int k = 0; k < 16; k++) begin
        got[127-8*k -: 8] = key_out;
        nv += int'(key_out_valid);
        tick;
      end
      chk($sformatf("kat%0d_round%0d", v, vt[v].round), got, vt[v].expect_rk);
      chk($sformatf("kat%0d_valid_cnt", v), 128'(nv), 128'(16));
    end

    // back-to-back rounds 10..0 for the current key
    model(k2);
    rq = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    stream(-1, "b2b");

    // illegal requests
    bad_start(4'd11, "round_11");
    rq = '{1};
    stream(5, "mid_stream");

    // stray key bytes during expansion, plus rk_start before ready
    model(k1);
    load_key(k1, 0, 1'b1);
    bad_start(4'd3, "during_expand");
    for (int c = 0; c < 100; c++) begin
      key_valid = 1'b1;
      key_in    = 8'($urandom);
      tick;
    end
    key_valid = 1'b0;
    wait_ready(n);
    rq = '{10, 3};
    stream(-1, "stray");

    // reset at expand byte 80
    load_key(k3, 0, 1'b0);
    repeat (64) tick;
    rst = 1'b1;
    #1;
    chk("rst_expand_busy", 128'(busy), 128'(0));
    chk("rst_expand_ready", 128'(keys_ready), 128'(0));
    chk("rst_expand_valid", 128'(key_out_valid), 128'(0));
    tick;
    rst = 1'b0;
    model(k3);
    load_key(k3, 1, 1'b0);
    wait_ready(n);
    rq = '{10, 0};
    stream(-1, "after_rst_expand");

    // reset at stream byte 7
    rk_round = 4'd4;
    rk_start = 1'b1;
    tick;
    rk_start = 1'b0;
    repeat (7) tick;
    chk("byte7_before_rst", 128'(key_out), 128'(mdl[4][127-56 -: 8]));
    rst = 1'b1;
    #1;
    chk("rst_stream_valid", 128'(key_out_valid), 128'(0));
    chk("rst_stream_data", 128'(key_out), 128'(0));
    chk("rst_stream_ready", 128'(keys_ready), 128'(0));
    chk("rst_stream_busy", 128'(busy), 128'(0));
    tick;
    rst = 1'b0;
    tick;
    load_key(k3, 0, 1'b0);
    wait_ready(n);
    rq = '{4};
    stream(-1, "after_rst_stream");

    // new key loaded in READY drops keys_ready at once
    model(k1);
    load_key(k1, 1, 1'b1);
    wait_ready(n);
    rq = '{0, 7};
    stream(-1, "reload");

    // random keys, gaps and round orders
    for (int it = 0; it < 3; it++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      model(kr);
      load_key(kr, -1, 1'b1);
      wait_ready(n);
      rq = {};
      for (int s = 0; s < 4; s++) rq.push_back(int'($urandom_range(0, 10)));
      stream(-1, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_schedule_serial.md
Name: key_schedule_serial

Overview:
- Byte-serial AES-128 key expansion and round-key server. Sits directly upstream of the decrypt round datapath and drives its 8-bit key input.
- Accepts the 16-byte cipher key one byte per cycle and expands all 11 round keys into internal storage at one byte per cycle.
- On request, streams any selected round key as 16 consecutive bytes, aligned with the round datapath's byte order.

Parameters:
- NR, 10, number of rounds; storage depth = 16*(NR+1) bytes.
- RW, 4, width of round index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  8  cipher key byte; byte 0 first, column-major (FIPS-197 order).
- key_valid  in  1  key_in is valid this cycle.
- rk_start  in  1  one-cycle pulse requesting a round-key stream.
- rk_round  in  RW  round index 0..NR, sampled with rk_start.
- key_out  out  8  round-key byte.
- key_out_valid  out  1  key_out is valid.
- keys_ready  out  1  all round keys are expanded and stored.
- busy  out  1  high in LOAD, EXPAND or STREAM.
- rk_err  out  1  one-cycle pulse on an illegal rk_start.

Behaviour:
- Reset: all outputs 0; state IDLE; byte counters 0. Storage contents are not reset, but keys_ready=0 makes them invalid.
- Storage: 176-byte register array w[0..175]; w[i] holds round i/16, byte i%16.
- IDLE/READY + key_valid: write w[0]=key_in, load counter becomes 1, enter LOAD, keys_ready drops to 0 in the same cycle.
- LOAD: each key_valid cycle writes w[cnt] and increments cnt. Gaps in key_valid are allowed. The 16th byte moves the block to EXPAND with i=16.
- EXPAND: one byte per cycle, i=16..175. No input stalls.
  - b=i%4, j=i/4.
  - If j%4==0: t = SBOX(w[4(j-1)+((b+1)%4)]), and if b==0 also XOR Rcon[j/4].
  - Otherwise t = w[i-4].
  - w[i] = w[i-16] XOR t.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - The write of byte 175 moves the block to READY; keys_ready=1 from the next cycle.
  - Total: 160 cycles from the last key byte to keys_ready.
- READY + rk_start with rk_round<=NR: enter STREAM.
  - key_out = w[16*rk_round + k] for k=0..15 on the 16 cycles following rk_start.
  - key_out_valid=1 on exactly those 16 cycles. Latency is 1 cycle, registered output.
  - After k=15, return to READY.
- Back-to-back streams: rk_start in the cycle holding k=15 is accepted, so the next stream's byte 0 follows with no bubble. This is required for consecutive decrypt rounds 10,9,...,1.
- Illegal rk_start pulses rk_err for one cycle with no other effect. Illegal means any of:
  - rk_round>NR;
  - keys_ready=0;
  - in STREAM before k=15.
- key_valid in EXPAND or STREAM is ignored.
- key_valid in READY starts a new LOAD and invalidates stored keys.
- key_out is 0 whenever key_out_valid=0.
- rst in any state returns the block to IDLE immediately (asynchronous). Any partial stream is aborted and keys_ready=0.
- No arithmetic other than XOR. Indices are computed in 8 bits.

Decomposition:
- Shared package aes_pkg holds:
  - NR and the key length constant;
  - the Rcon table (10 x 8-bit);
  - the state enum IDLE/LOAD/EXPAND/READY/STREAM.
- Reuse the existing sub_bytes with mode=0 (forward S-box) as the single sub-module instance. No other sub-modules.

Test Plan:
- Load key 000102030405060708090a0b0c0d0e0f -> keys_ready asserts 160 cycles after the last byte. Round 1 stream = d6aa74fdd2af72fadaa678f1d6ab76fe. Round 10 stream = 13111d7fe3944a17f307a78b4d2b30c5.
- Load key 2b7e151628aed2a6abf7158809cf4f3c with 2-cycle gaps between key_valid pulses -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. Round 0 = the key itself.
- Back-to-back rk_start for rounds 10,9,...,0, each pulse issued on the k=15 cycle -> 176 contiguous valid bytes with no bubble, each round correct.
- rk_start with rk_round=11, rk_start before keys_ready, and rk_start mid-stream -> rk_err pulses once each. The stream in progress is unaffected and key_out_valid stays 0 otherwise.
- Assert rst at EXPAND byte 80 and again at stream byte 7 -> outputs 0 asynchronously. Re-loading the key produces correct keys.
- key_valid asserted with stray data during EXPAND -> ignored, expansion results unchanged. A new key loaded in READY drops keys_ready the same cycle and re-expands to the new schedule.
